// File: rtl/datapath_ctrl.sv
// Sequencing controller for the capture/sum datapath: collects four operands over a
// valid/ready handshake, strobes A..D, pulses en, then reports done, timeout err and op_count.
module datapath_ctrl #(
    parameter int HOLD_RESULT = 0,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic                 abort,
    input  logic                 ack,
    output logic                 ready,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    output logic                 D,
    output logic                 en,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {S_A, S_B, S_C, S_D, S_EXEC, S_DONE} state_t;

    state_t                 state_q;
    logic                   err_q;
    logic [CNT_WIDTH-1:0]   op_count_q;
    logic [TW-1:0]          timer_q;
    logic                   collect;
    logic                   hs;

    function automatic state_t next_operand(input state_t s);
        case (s)
            S_A:     return S_B;
            S_B:     return S_C;
            S_C:     return S_D;
            default: return S_EXEC;
        endcase
    endfunction

    // Strobes are gated by rst_n so nothing is captured while reset is held.
    assign collect  = (state_q == S_A) || (state_q == S_B) ||
                      (state_q == S_C) || (state_q == S_D);
    assign hs       = collect && valid && !abort && rst_n;
    assign ready    = collect;
    assign A        = hs && (state_q == S_A);
    assign B        = hs && (state_q == S_B);
    assign C        = hs && (state_q == S_C);
    assign D        = hs && (state_q == S_D);
    assign en       = (state_q == S_EXEC) && !abort && rst_n;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_A);
    assign err      = err_q;
    assign op_count = op_count_q;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= S_A;
            op_count_q <= '0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            err_q <= 1'b0;
            if (abort) begin
                state_q <= S_A;
                timer_q <= '0;
            end else begin
                case (state_q)
                    S_A, S_B, S_C, S_D: begin
                        if (valid) begin
                            state_q <= next_operand(state_q);
                            timer_q <= '0;
                        end else if (state_q != S_A && TIMEOUT_CYC > 0) begin
                            if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                                state_q <= S_A;
                                timer_q <= '0;
                                err_q   <= 1'b1;
                            end else begin
                                timer_q <= timer_q + TW'(1);
                            end
                        end
                    end
                    S_EXEC: begin
                        state_q    <= S_DONE;
                        op_count_q <= op_count_q + CNT_WIDTH'(1);
                    end
                    S_DONE: begin
                        if (HOLD_RESULT == 0 || ack) state_q <= S_A;
                    end
                    default: state_q <= S_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: two instances (no-hold/timeout 4, hold/timeout 16) driving a
// small downstream capture/sum register model, checked cycle by cycle against a reference.
module tb_datapath_ctrl;
    localparam int CW = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          rst_s[2], valid_s[2], abort_s[2], ack_s[2];
    logic [3:0]    din_s[2];
    logic          ready_o[2], a_o[2], b_o[2], c_o[2], d_o[2];
    logic          en_o[2], done_o[2], busy_o[2], err_o[2];
    logic [CW-1:0] cnt_o[2];

    datapath_ctrl #(.HOLD_RESULT(0), .TIMEOUT_CYC(4), .CNT_WIDTH(CW)) dut0 (
        .clock(clock), .rst_n(rst_s[0]), .valid(valid_s[0]), .abort(abort_s[0]), .ack(ack_s[0]),
        .ready(ready_o[0]), .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .D(d_o[0]), .en(en_o[0]),
        .done(done_o[0]), .busy(busy_o[0]), .err(err_o[0]), .op_count(cnt_o[0]));

    datapath_ctrl #(.HOLD_RESULT(1), .TIMEOUT_CYC(16), .CNT_WIDTH(CW)) dut1 (
        .clock(clock), .rst_n(rst_s[1]), .valid(valid_s[1]), .abort(abort_s[1]), .ack(ack_s[1]),
        .ready(ready_o[1]), .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .D(d_o[1]), .en(en_o[1]),
        .done(done_o[1]), .busy(busy_o[1]), .err(err_o[1]), .op_count(cnt_o[1]));

    // Downstream datapath: operand registers captured on strobes, result = A+B-C-D mod 32.
    logic [3:0] ra[2], rb[2], rc[2], rd[2];
    logic [4:0] res[2];
    always @(posedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_s[g]) begin
                ra[g] <= '0; rb[g] <= '0; rc[g] <= '0; rd[g] <= '0; res[g] <= '0;
            end else begin
                if (a_o[g]) ra[g] <= din_s[g];
                if (b_o[g]) rb[g] <= din_s[g];
                if (c_o[g]) rc[g] <= din_s[g];
                if (d_o[g]) rd[g] <= din_s[g];
                if (en_o[g]) res[g] <= {1'b0, ra[g]} + {1'b0, rb[g]} - {1'b0, rc[g]} - {1'b0, rd[g]};
            end
        end
    end

    // Reference: p = operands collected so far (0..3), 4 = executing, 5 = result shown.
    int HOLDP[2] = '{0, 1};
    int TOP[2]   = '{4, 16};
    int p[2], idle[2], mcnt[2], mres[2];
    int ops[2][4];
    bit merr[2];
    bit chk_on = 1'b0;
    int nchk = 0;
    int nerr = 0;

    task automatic drive(input int i, input logic v, input logic [3:0] d,
                         input logic ab, input logic ak, input logic rn);
        valid_s[i] = v; din_s[i] = d; abort_s[i] = ab; ack_s[i] = ak; rst_s[i] = rn;
    endtask

    task automatic check(input int i);
        bit col, hs;
        logic [8:0] exp_v, obs_v;
        col   = p[i] < 4;
        hs    = col && valid_s[i] && !abort_s[i] && rst_s[i];
        exp_v = {col, hs && p[i] == 0, hs && p[i] == 1, hs && p[i] == 2, hs && p[i] == 3,
                 p[i] == 4 && !abort_s[i] && rst_s[i], p[i] == 5, p[i] != 0, merr[i]};
        obs_v = {ready_o[i], a_o[i], b_o[i], c_o[i], d_o[i], en_o[i], done_o[i], busy_o[i], err_o[i]};
        nchk++;
        assert (obs_v === exp_v) else begin
            nerr++;
            $error("FAIL outs%0d t=%0t observed=%b expected=%b (rdy,A,B,C,D,en,done,busy,err)",
                   i, $time, obs_v, exp_v);
        end
        nchk++;
        assert (cnt_o[i] === CW'(mcnt[i])) else begin
            nerr++;
            $error("FAIL op_count%0d t=%0t observed=%0d expected=%0d", i, $time, cnt_o[i], mcnt[i]);
        end
        nchk++;
        assert (res[i] === 5'(mres[i])) else begin
            nerr++;
            $error("FAIL result%0d t=%0t observed=%0d expected=%0d", i, $time, res[i], mres[i]);
        end
    endtask

    task automatic model_update(input int i);
        bit col, hs, en_e;
        col  = p[i] < 4;
        hs   = col && valid_s[i] && !abort_s[i] && rst_s[i];
        en_e = p[i] == 4 && !abort_s[i] && rst_s[i];
        if (!rst_s[i]) begin
            p[i] = 0; mcnt[i] = 0; merr[i] = 0; idle[i] = 0; mres[i] = 0;
            return;
        end
        merr[i] = 0;
        if (hs) ops[i][p[i]] = int'(din_s[i]);
        if (en_e) mres[i] = (ops[i][0] + ops[i][1] - ops[i][2] - ops[i][3]) & 31;
        if (abort_s[i]) begin
            p[i] = 0; idle[i] = 0;
        end else if (col) begin
            if (valid_s[i]) begin
                p[i] = p[i] + 1; idle[i] = 0;
            end else if (p[i] > 0 && TOP[i] > 0) begin
                idle[i] = idle[i] + 1;
                if (idle[i] == TOP[i]) begin p[i] = 0; idle[i] = 0; merr[i] = 1; end
            end
        end else if (p[i] == 4) begin
            p[i] = 5; mcnt[i] = (mcnt[i] + 1) % 256;
        end else if (HOLDP[i] == 0 || ack_s[i]) begin
            p[i] = 0;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (chk_on) for (int i = 0; i < 2; i++) check(i);
        @(posedge clock);
        for (int i = 0; i < 2; i++) model_update(i);
        #1;
    endtask

    task automatic feed(input int i, input logic [3:0] d);
        valid_s[i] = 1'b1; din_s[i] = d;
        tick();
        valid_s[i] = 1'b0;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nchk++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            p[i] = 0; idle[i] = 0; mcnt[i] = 0; mres[i] = 0; merr[i] = 0;
            for (int k = 0; k < 4; k++) ops[i][k] = 0;
        end
        // Reset held with valid high: strobes must stay low.
        drive(0, 1, 4'd5, 0, 0, 0); drive(1, 1, 4'd5, 0, 0, 0);
        tick();
        chk_on = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 1); drive(1, 0, 0, 0, 0, 1);
        tick();
        expect_val("reset_busy", 32'(busy_o[0]), 0);
        expect_val("reset_count", 32'(cnt_o[0]), 0);

        // Basic: 9+7-3-2
        feed(0, 9); feed(0, 7); feed(0, 3); feed(0, 2);
        tick();
        expect_val("basic_done", 32'(done_o[0]), 1);
        expect_val("basic_result", 32'(res[0]), 11);
        expect_val("basic_count", 32'(cnt_o[0]), 1);
        tick();

        // Wrap: 0+0-15-15 mod 32
        feed(0, 0); feed(0, 0); feed(0, 15); feed(0, 15);
        tick();
        expect_val("wrap_result", 32'(res[0]), 2);
        expect_val("wrap_count", 32'(cnt_o[0]), 2);
        tick();

        // Gaps of 3 idle cycles between B and C, then hold until ack
        feed(1, 9); feed(1, 7);
        tick(); tick(); tick();
        expect_val("gap_busy", 32'(busy_o[1]), 1);
        feed(1, 3); feed(1, 2);
        tick();
        expect_val("gap_result", 32'(res[1]), 11);
        expect_val("gap_err", 32'(err_o[1]), 0);
        drive(1, 1, 4'd6, 0, 0, 1);
        tick(); tick();
        expect_val("hold_done", 32'(done_o[1]), 1);
        drive(1, 0, 0, 0, 1, 1);
        tick();
        drive(1, 0, 0, 0, 0, 1);
        expect_val("ack_release", 32'(busy_o[1]), 0);

        // Timeout after B with 4 idle cycles
        feed(0, 5); feed(0, 6);
        tick(); tick(); tick(); tick();
        expect_val("timeout_err", 32'(err_o[0]), 1);
        expect_val("timeout_state", 32'(busy_o[0]), 0);
        tick();
        expect_val("timeout_err_pulse", 32'(err_o[0]), 0);
        feed(0, 1); feed(0, 2); feed(0, 3); feed(0, 4);
        tick();
        expect_val("after_timeout_result", 32'(res[0]), 28);
        expect_val("after_timeout_count", 32'(cnt_o[0]), 3);
        tick();

        // Abort with valid in S_C
        feed(0, 8); feed(0, 8);
        drive(0, 1, 4'd5, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        expect_val("abort_c_state", 32'(busy_o[0]), 0);
        expect_val("abort_c_count", 32'(cnt_o[0]), 3);

        // Abort in S_EXEC keeps the old result
        feed(0, 1); feed(0, 1); feed(0, 1); feed(0, 1);
        drive(0, 0, 0, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        expect_val("abort_exec_result", 32'(res[0]), 28);
        expect_val("abort_exec_count", 32'(cnt_o[0]), 3);

        // Reset held in S_C
        feed(1, 4); feed(1, 4);
        drive(1, 1, 4'd4, 0, 0, 0);
        tick(); tick();
        drive(1, 0, 0, 0, 0, 1);
        expect_val("reset_mid_count", 32'(cnt_o[1]), 0);
        expect_val("reset_mid_state", 32'(busy_o[1]), 0);
        tick();

        // 256 operations wrap op_count back to 0
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < 4; j++) feed(0, 4'($urandom));
            tick(); tick();
        end
        expect_val("count_wrap", 32'(cnt_o[0]), 0);

        // Random traffic on both instances
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++)
                drive(i, $urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 19) == 0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 99) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
